// File: rtl/activation_skew_feeder_if.sv
// Handshake and lane bus between an upstream activation source and the
// skew feeder that drives the row inputs of a systolic PE array.
//   master : upstream side (drives in_valid/in_vector/in_last/scan_en)
//   slave  : feeder side   (drives in_ready/act_out/act_valid/batch_done/busy)
interface activation_skew_feeder_if #(
  parameter int unsigned SYSTOLIC_SIZE    = 8,
  parameter int unsigned ACTIVATION_WIDTH = 8
);
  logic                                        in_valid;
  logic                                        in_ready;
  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   in_vector;
  logic                                        in_last;
  logic                                        scan_en;
  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]   act_out;
  logic [SYSTOLIC_SIZE-1:0]                    act_valid;
  logic                                        batch_done;
  logic                                        busy;

  modport master (
    output in_valid, in_vector, in_last, scan_en,
    input  in_ready, act_out, act_valid, batch_done, busy
  );

  modport slave (
    input  in_valid, in_vector, in_last, scan_en,
    output in_ready, act_out, act_valid, batch_done, busy
  );
endinterface

// File: rtl/activation_skew_feeder.sv
// Activation skew feeder: accepts one activation vector per cycle and
// presents element i on row i of the PE array i+1 cycles after the accept,
// producing the diagonal wavefront a systolic array expects. Idle cycles
// inject zero/invalid bubbles; lane chains never stall.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.slave  : in_valid/in_ready/in_vector/in_last/scan_en in,
//                act_out/act_valid per lane, batch_done pulse, busy
module activation_skew_feeder #(
  parameter int unsigned SYSTOLIC_SIZE    = 8,
  parameter int unsigned ACTIVATION_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  activation_skew_feeder_if.slave  bus
);
  localparam int unsigned N  = SYSTOLIC_SIZE;
  localparam int unsigned AW = ACTIVATION_WIDTH;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           accept;
  logic [N-1:0]   tag_q;
  logic [N*AW-1:0] act_out_w;
  logic [N-1:0]   act_valid_w;

  assign bus.in_ready = (state_q != DRAIN) && !bus.scan_en;
  assign accept       = bus.in_valid && bus.in_ready;
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (bus.in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lane i keeps i+1 stages: stage 0 is the lane-0-aligned input register,
  // newest data in the low slice, the oldest (output) slice on top.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [AW-1:0]         head;
    logic [(i+1)*AW-1:0]   data_q;
    logic [i:0]            valid_q;

    assign head = accept ? bus.in_vector[i*AW +: AW] : '0;

    if (i == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= '0;
        end else begin
          data_q  <= head;
          valid_q <= accept;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= '0;
        end else begin
          data_q  <= {data_q[i*AW-1:0], head};
          valid_q <= {valid_q[i-1:0], accept};
        end
      end
    end

    assign act_out_w[i*AW +: AW] = data_q[(i+1)*AW-1 -: AW];
    assign act_valid_w[i]        = valid_q[i];
  end

  // The last tag only needs to ride alongside the longest lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tag_q <= '0;
    else        tag_q <= {tag_q[N-2:0], accept && bus.in_last};
  end

  assign bus.act_out    = act_out_w;
  assign bus.act_valid  = act_valid_w;
  assign bus.batch_done = act_valid_w[N-1] && tag_q[N-1];
endmodule

// File: tb/tb_activation_skew_feeder.sv
// Directed bench for activation_skew_feeder at SYSTOLIC_SIZE=4, 8-bit
// activations; every expected value below is worked out by hand.
module tb_activation_skew_feeder;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  activation_skew_feeder_if #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(AW)) bus ();

  activation_skew_feeder #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_lanes(input string tag, input logic [31:0] eo, input logic [3:0] ev);
    check({tag, ".act_out"},   64'(bus.act_out),   64'(eo));
    check({tag, ".act_valid"}, 64'(bus.act_valid), 64'(ev));
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic bd);
    check({tag, ".in_ready"},   64'(bus.in_ready),   64'(rdy));
    check({tag, ".busy"},       64'(bus.busy),       64'(bsy));
    check({tag, ".batch_done"}, 64'(bus.batch_done), 64'(bd));
  endtask

  // Drive inputs for one cycle, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [31:0] vec, input logic last, input logic scan);
    bus.in_valid  = v;
    bus.in_vector = vec;
    bus.in_last   = last;
    bus.scan_en   = scan;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic run_single(input string tag);
    step(1'b1, 32'h04030201, 1'b1, 1'b0);
    chk_lanes({tag, ".e0"}, 32'h00000001, 4'b0001); chk_ctl({tag, ".e0"}, 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes({tag, ".e1"}, 32'h00000200, 4'b0010); chk_ctl({tag, ".e1"}, 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes({tag, ".e2"}, 32'h00030000, 4'b0100); chk_ctl({tag, ".e2"}, 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes({tag, ".e3"}, 32'h04000000, 4'b1000); chk_ctl({tag, ".e3"}, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_vector = '0;
    bus.in_last   = 1'b0;
    bus.scan_en   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_lanes("rst", 32'h0, 4'b0000);
    chk_ctl("rst", 1'b1, 1'b0, 1'b0);
    bus.scan_en = 1'b1;
    #1;
    check("rst.scan_ready", 64'(bus.in_ready), 64'(1'b0));
    bus.scan_en = 1'b0;
    #1;
    rst_n = 1'b1;

    // Single vector, accepted on the first edge after reset release.
    run_single("single");
    idle();
    chk_lanes("single.after", 32'h0, 4'b0000); chk_ctl("single.after", 1'b1, 1'b0, 1'b0);

    // Three back-to-back vectors, then a new batch in the batch_done cycle.
    step(1'b1, 32'h13121110, 1'b0, 1'b0);
    chk_lanes("burst.e0", 32'h00000010, 4'b0001); chk_ctl("burst.e0", 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h23222120, 1'b0, 1'b0);
    chk_lanes("burst.e1", 32'h00001120, 4'b0011);
    step(1'b1, 32'h33323130, 1'b1, 1'b0);
    chk_lanes("burst.e2", 32'h00122130, 4'b0111); chk_ctl("burst.e2", 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes("burst.e3", 32'h13223100, 4'b1110); chk_ctl("burst.e3", 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes("burst.e4", 32'h23320000, 4'b1100); chk_ctl("burst.e4", 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes("burst.e5", 32'h33000000, 4'b1000); chk_ctl("burst.e5", 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h44434241, 1'b1, 1'b0);
    chk_lanes("b2b.e6", 32'h00000041, 4'b0001); chk_ctl("b2b.e6", 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes("b2b.e7", 32'h00004200, 4'b0010); check("b2b.e7.batch_done", 64'(bus.batch_done), 64'(1'b0));
    idle();
    chk_lanes("b2b.e8", 32'h00430000, 4'b0100); check("b2b.e8.batch_done", 64'(bus.batch_done), 64'(1'b0));
    idle();
    chk_lanes("b2b.e9", 32'h44000000, 4'b1000); chk_ctl("b2b.e9", 1'b1, 1'b0, 1'b1);

    // One-cycle input gap mid-batch becomes a skewed bubble.
    step(1'b1, 32'h13121110, 1'b0, 1'b0);
    chk_lanes("gap.e0", 32'h00000010, 4'b0001);
    idle();
    chk_lanes("gap.e1", 32'h00001100, 4'b0010); chk_ctl("gap.e1", 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h23222120, 1'b1, 1'b0);
    chk_lanes("gap.e2", 32'h00120020, 4'b0101); chk_ctl("gap.e2", 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes("gap.e3", 32'h13002100, 4'b1010); check("gap.e3.batch_done", 64'(bus.batch_done), 64'(1'b0));
    idle();
    chk_lanes("gap.e4", 32'h00220000, 4'b0100);
    idle();
    chk_lanes("gap.e5", 32'h23000000, 4'b1000); chk_ctl("gap.e5", 1'b1, 1'b0, 1'b1);

    // scan_en blocks accepts while in-flight data keeps moving.
    step(1'b1, 32'h13121110, 1'b0, 1'b0);
    chk_lanes("scan.e0", 32'h00000010, 4'b0001);
    bus.scan_en = 1'b1;
    bus.in_vector = 32'h23222120;
    bus.in_last = 1'b1;
    #1;
    check("scan.ready_low", 64'(bus.in_ready), 64'(1'b0));
    step(1'b1, 32'h23222120, 1'b1, 1'b1);
    chk_lanes("scan.e1", 32'h00001100, 4'b0010); chk_ctl("scan.e1", 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h23222120, 1'b1, 1'b1);
    chk_lanes("scan.e2", 32'h00120000, 4'b0100);
    step(1'b1, 32'h23222120, 1'b1, 1'b0);
    chk_lanes("scan.e3", 32'h13000020, 4'b1001); chk_ctl("scan.e3", 1'b0, 1'b1, 1'b0);
    idle();
    chk_lanes("scan.e4", 32'h00002100, 4'b0010);
    idle();
    chk_lanes("scan.e5", 32'h00220000, 4'b0100);
    idle();
    chk_lanes("scan.e6", 32'h23000000, 4'b1000); chk_ctl("scan.e6", 1'b1, 1'b0, 1'b1);

    // Reset during DRAIN with lanes 1 and 2 holding valid data.
    step(1'b1, 32'h13121110, 1'b0, 1'b0);
    step(1'b1, 32'h23222120, 1'b1, 1'b0);
    chk_lanes("abort.e1", 32'h00001120, 4'b0011);
    idle();
    chk_lanes("abort.e2", 32'h00122100, 4'b0110); chk_ctl("abort.e2", 1'b0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_lanes("abort.rst", 32'h0, 4'b0000); chk_ctl("abort.rst", 1'b1, 1'b0, 1'b0);
    idle();
    check("abort.hold1.batch_done", 64'(bus.batch_done), 64'(1'b0));
    idle();
    chk_lanes("abort.hold2", 32'h0, 4'b0000);
    rst_n = 1'b1;
    run_single("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
